rv_mem_arbiter: RTL and testbench
=================================

// Module: rv_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between rv_cpu instruction fetch (im_*) and data (dm_*) ports.
//  Sits between rv_cpu and the RAM macro in the SoC top; replaces the dual-port behavioural memory.
//  Data accesses have priority; a starvation counter guarantees fetch progress.
// PARAMETERS
//  g_ram_aw      12  RAM word-address width (RAM = 2**g_ram_aw 32-bit words)
//  g_starve_max  4   consecutive denied fetch cycles before fetch is forced (1..15)
// PORTS
//  clk_i            in   1   clock
//  rst_n_i          in   1   synchronous reset, active low
//  im_addr_i        in   32  fetch byte address (word aligned)
//  im_data_o        out  32  fetched instruction
//  im_valid_o       out  1   im_data_o valid for the im_addr_i sampled one cycle earlier
//  dm_addr_i        in   32  data byte address
//  dm_data_s_i      in   32  store data
//  dm_data_select_i in   4   store byte enables
//  dm_store_i       in   1   store request (one-cycle strobe, only when dm_ready_o=1)
//  dm_load_i        in   1   load request (one-cycle strobe, only when dm_ready_o=1)
//  dm_data_l_o      out  32  load data
//  dm_load_done_o   out  1   one-cycle pulse, dm_data_l_o valid
//  dm_store_done_o  out  1   one-cycle pulse, store written to RAM
//  dm_ready_o       out  1   no data request pending; new request may be issued
//  ram_addr_o       out  g_ram_aw  RAM word address
//  ram_wdata_o      out  32  RAM write data
//  ram_we_o         out  1   RAM write strobe
//  ram_bwe_o        out  4   RAM byte write enables
//  ram_rdata_i      in   32  RAM read data, 1-cycle latency after ram_addr_o
// BEHAVIOUR
//  Reset (rst_n_i=0 at clk edge): state IDLE; im_valid_o, dm_load_done_o, dm_store_done_o, ram_we_o = 0;
//   dm_ready_o = 1; ram_bwe_o = 0; im_data_o, dm_data_l_o, ram_addr_o = 0; starve counter = 0; pending cleared.
//   Reset mid-access discards the access; no done pulse is emitted afterwards.
//  Address: ram_addr_o = addr[g_ram_aw+1:2]; upper bits ignored (wraps modulo RAM size).
//  Pending reg: dm strobe latched (addr, data, sel, type) the cycle it arrives; dm_ready_o=0 while pending
//   or in flight. Strobe with dm_ready_o=0 is a protocol error: ignored. dm_load_i&dm_store_i together: store wins.
//  Grant per cycle (one RAM op): if starve==g_starve_max -> FETCH; else if DM pending/strobe -> DM; else FETCH.
//   Strobe is granted same cycle it arrives (combinational bypass of pending reg).
//  FSM states: IDLE, FETCH, DM_RD, DM_WR (state = op issued last cycle).
//   FETCH: next cycle im_valid_o=1, im_data_o=ram_rdata_i. Any non-FETCH cycle: im_valid_o=0.
//   DM_RD: next cycle dm_load_done_o=1, dm_data_l_o=ram_rdata_i (held until next load), dm_ready_o returns to 1.
//   DM_WR: ram_we_o=1, ram_bwe_o=sel in the grant cycle; dm_store_done_o=1 next cycle, dm_ready_o returns to 1.
//  Latency: load 1 cycle from strobe when granted; worst case 2 (forced fetch). Store identical.
//  Starve counter: +1 per cycle fetch denied by DM grant, saturates at g_starve_max; cleared on FETCH grant.
//  Back-to-back: new dm strobe allowed on the done cycle (dm_ready_o=1); fetch resumes when DM idle.
//  Read-after-write same address next cycle returns the new data (RAM write-first assumed of macro).
// CONFIGURATION
//  RV_MEM_ARB_STATS_EN defined: adds outputs stat_fetch_o, stat_dm_o, stat_stall_o (32 bit each):
//   grant counts for FETCH, DM and cycles fetch was denied; wrap at 2**32; cleared by reset.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  rv_defs.v / package: state encoding (ARB_IDLE, ARB_FETCH, ARB_DM_RD, ARB_DM_WR), LDST-independent
//   request-type constants. One sub-module: rv_mem_arb_starve (saturating counter + force flag).
//  Byte/half alignment of load data stays in rv_cpu writeback; arbiter moves full words only.
// TESTING
//  1 Reset release, no DM traffic, mem[0x10]=0xDEADBEEF, im_addr_i=0x40 -> im_valid_o=1, im_data_o=0xDEADBEEF next cycle, every cycle.
//  2 dm_load_i at 0x80 (mem=0x12345678) while fetching -> im_valid_o=0 one cycle, dm_load_done_o+data 0x12345678 next cycle.
//  3 dm_store_i 0x100, data 0xAABBCCDD, sel=4'b0010 over 0x11111111 -> mem=0x1111CC11, dm_store_done_o 1 cycle later.
//  4 DM strobes every ready cycle, g_starve_max=4 -> fetch granted exactly once per 5 cycles; dm_ready_o low on forced cycle.
//  5 Address 0x4000+0x40 with g_ram_aw=12 -> aliases word 0x10; store then load returns stored value.
//  6 rst_n_i low in cycle after dm_load_i -> no dm_load_done_o; dm_ready_o=1, im_valid_o=0 after reset.

Source files
------------

// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types for the instruction/data single-port RAM arbiter.
// State encoding and data-request bundle carried through the pending register.
package rv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DM_RD,
        ARB_DM_WR
    } arb_state_e;

    typedef enum logic {
        REQ_LOAD  = 1'b0,
        REQ_STORE = 1'b1
    } req_kind_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        req_kind_e   kind;
    } dm_req_t;

    localparam int unsigned STARVE_CW = 4;

    function automatic req_kind_e kind_of(input logic store);
        return store ? REQ_STORE : REQ_LOAD;
    endfunction

endpackage

// File: rtl/rv_mem_arb_starve.sv
// Fetch starvation guard: counts consecutive fetch denials and
// raises force_o once the limit is reached.
module rv_mem_arb_starve
    import rv_mem_arbiter_pkg::*;
#(
    parameter int unsigned g_starve_max = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic deny_i,
    input  logic clear_i,
    output logic force_o
);

    localparam logic [STARVE_CW-1:0] MAX = STARVE_CW'(g_starve_max);

    logic [STARVE_CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (deny_i && cnt_q != MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign force_o = (cnt_q == MAX);

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-port RAM between rv_cpu fetch and data ports; data wins,
// starvation guard forces fetch. RV_MEM_ARB_STATS_EN adds grant counters.
module rv_mem_arbiter
    import rv_mem_arbiter_pkg::*;
#(
    parameter int unsigned g_ram_aw     = 12,
    parameter int unsigned g_starve_max = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [31:0]         im_addr_i,
    output logic [31:0]         im_data_o,
    output logic                im_valid_o,
    input  logic [31:0]         dm_addr_i,
    input  logic [31:0]         dm_data_s_i,
    input  logic [3:0]          dm_data_select_i,
    input  logic                dm_store_i,
    input  logic                dm_load_i,
    output logic [31:0]         dm_data_l_o,
    output logic                dm_load_done_o,
    output logic                dm_store_done_o,
    output logic                dm_ready_o,
    output logic [g_ram_aw-1:0] ram_addr_o,
    output logic [31:0]         ram_wdata_o,
    output logic                ram_we_o,
    output logic [3:0]          ram_bwe_o,
    input  logic [31:0]         ram_rdata_i
`ifdef RV_MEM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_fetch_o,
    output logic [31:0]         stat_dm_o,
    output logic [31:0]         stat_stall_o
`endif
);

    arb_state_e  state_q;
    dm_req_t     pend_q;
    dm_req_t     new_req;
    dm_req_t     cur_req;
    logic        pend_valid_q;
    logic        rdy_q;
    logic        take;
    logic        req_dm;
    logic        force_fetch;
    logic        grant_dm;
    logic        grant_fetch;
    logic [31:0] im_hold_q;
    logic [31:0] ld_hold_q;
    logic        unused_bits;

    always_comb begin
        new_req      = '0;
        new_req.addr = dm_addr_i;
        new_req.data = dm_data_s_i;
        new_req.sel  = dm_data_select_i;
        new_req.kind = kind_of(dm_store_i);
    end

    // Strobes seen while not ready are dropped; a fresh strobe bypasses
    // the pending register so it can use the RAM in its arrival cycle.
    assign take        = rdy_q & (dm_load_i | dm_store_i);
    assign req_dm      = pend_valid_q | take;
    assign cur_req     = pend_valid_q ? pend_q : new_req;
    assign grant_dm    = req_dm & ~force_fetch;
    assign grant_fetch = ~grant_dm;

    rv_mem_arb_starve #(
        .g_starve_max(g_starve_max)
    ) u_starve (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .deny_i (grant_dm),
        .clear_i(grant_fetch),
        .force_o(force_fetch)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ARB_IDLE;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            rdy_q        <= 1'b1;
            im_hold_q    <= '0;
            ld_hold_q    <= '0;
        end else begin
            if (state_q == ARB_FETCH) im_hold_q <= ram_rdata_i;
            if (state_q == ARB_DM_RD) ld_hold_q <= ram_rdata_i;
            if (grant_fetch) begin
                state_q <= ARB_FETCH;
            end else if (cur_req.kind == REQ_STORE) begin
                state_q <= ARB_DM_WR;
            end else begin
                state_q <= ARB_DM_RD;
            end
            if (grant_dm) begin
                pend_valid_q <= 1'b0;
                rdy_q        <= 1'b1;
            end else if (take) begin
                pend_valid_q <= 1'b1;
                pend_q       <= new_req;
                rdy_q        <= 1'b0;
            end
        end
    end

    // Strobes are qualified by reset so an access cut by reset never completes.
    assign im_valid_o      = rst_n_i & (state_q == ARB_FETCH);
    assign dm_load_done_o  = rst_n_i & (state_q == ARB_DM_RD);
    assign dm_store_done_o = rst_n_i & (state_q == ARB_DM_WR);
    assign dm_ready_o      = rdy_q;

    assign im_data_o   = (state_q == ARB_FETCH) ? ram_rdata_i : im_hold_q;
    assign dm_data_l_o = (state_q == ARB_DM_RD) ? ram_rdata_i : ld_hold_q;

    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_bwe_o   = 4'b0000;
        ram_wdata_o = '0;
        if (rst_n_i) begin
            if (grant_dm) begin
                ram_addr_o = cur_req.addr[g_ram_aw+1:2];
                if (cur_req.kind == REQ_STORE) begin
                    ram_we_o    = 1'b1;
                    ram_bwe_o   = cur_req.sel;
                    ram_wdata_o = cur_req.data;
                end
            end else begin
                ram_addr_o = im_addr_i[g_ram_aw+1:2];
            end
        end
    end

    assign unused_bits = ^{im_addr_i[31:g_ram_aw+2], im_addr_i[1:0],
                           cur_req.addr[31:g_ram_aw+2], cur_req.addr[1:0]};

`ifdef RV_MEM_ARB_STATS_EN
    logic [31:0] n_fetch_q;
    logic [31:0] n_dm_q;
    logic [31:0] n_stall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            n_fetch_q <= '0;
            n_dm_q    <= '0;
            n_stall_q <= '0;
        end else begin
            if (grant_fetch) n_fetch_q <= n_fetch_q + 32'd1;
            if (grant_dm) begin
                n_dm_q    <= n_dm_q + 32'd1;
                n_stall_q <= n_stall_q + 32'd1;
            end
        end
    end

    assign stat_fetch_o = n_fetch_q;
    assign stat_dm_o    = n_dm_q;
    assign stat_stall_o = n_stall_q;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_rv_mem_arbiter;

    localparam int AW    = 12;
    localparam int SMAX  = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   im_addr = '0;
    logic [31:0]   im_data;
    logic          im_valid;
    logic [31:0]   dm_addr = '0;
    logic [31:0]   dm_wdata = '0;
    logic [3:0]    dm_sel = '0;
    logic          dm_store = 1'b0;
    logic          dm_load = 1'b0;
    logic [31:0]   ld_data;
    logic          ld_done;
    logic          st_done;
    logic          ready;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic [3:0]    ram_bwe;
    logic [31:0]   ram_rdata = '0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.g_ram_aw(AW), .g_starve_max(SMAX)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .im_addr_i       (im_addr),
        .im_data_o       (im_data),
        .im_valid_o      (im_valid),
        .dm_addr_i       (dm_addr),
        .dm_data_s_i     (dm_wdata),
        .dm_data_select_i(dm_sel),
        .dm_store_i      (dm_store),
        .dm_load_i       (dm_load),
        .dm_data_l_o     (ld_data),
        .dm_load_done_o  (ld_done),
        .dm_store_done_o (st_done),
        .dm_ready_o      (ready),
        .ram_addr_o      (ram_addr),
        .ram_wdata_o     (ram_wdata),
        .ram_we_o        (ram_we),
        .ram_bwe_o       (ram_bwe),
        .ram_rdata_i     (ram_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Behavioural write-first RAM with a backdoor load port.
    logic [31:0]   mem [DEPTH];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = '0;
    logic [31:0]   wr_word;
    assign wr_word = merge(mem[ram_addr], ram_wdata, ram_bwe);

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else begin
            if (ram_we) mem[ram_addr] <= wr_word;
            ram_rdata <= ram_we ? wr_word : mem[ram_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bd(input int a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_addr = AW'(a);
        bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic step(input logic r, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] im);
        @(posedge clk);
        #1;
        rst_n = r;
        dm_load = ld;
        dm_store = st;
        dm_addr = a;
        dm_wdata = d;
        dm_sel = s;
        im_addr = im;
        @(negedge clk);
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] im;
        logic        e_imv;
        logic [31:0] e_imd;
        logic        e_ldd;
        logic [31:0] e_ldata;
        logic        e_std;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic [31:0] im, input logic imv,
                                input logic [31:0] imd, input logic ldd,
                                input logic [31:0] ldata, input logic std);
        vec_t v;
        v.ld = ld; v.st = st; v.a = a; v.d = d; v.s = s; v.im = im;
        v.e_imv = imv; v.e_imd = imd; v.e_ldd = ldd;
        v.e_ldata = ldata; v.e_std = std;
        return v;
    endfunction

    // Reference model: outputs expected in the current cycle plus a request queue.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        st;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] refm [DEPTH];
    logic        m_imv, m_ldd, m_std, m_rdy;
    logic [31:0] m_imd, m_ldata;
    int          starve;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_imv = 0; m_ldd = 0; m_std = 0; m_rdy = 1;
        m_imd = '0; m_ldata = '0; starve = 0;
    endtask

    task automatic model_step();
        mreq_t r;
        mreq_t nr;
        int    w;
        chk("rnd im_valid", im_valid, m_imv);
        if (m_imv) chk("rnd im_data", im_data, m_imd);
        chk("rnd ld_done", ld_done, m_ldd);
        chk("rnd ld_data", ld_data, m_ldata);
        chk("rnd st_done", st_done, m_std);
        chk("rnd ready", ready, m_rdy);
        if (m_rdy && (dm_load || dm_store)) begin
            nr.a = dm_addr; nr.d = dm_wdata; nr.s = dm_sel; nr.st = dm_store;
            mq.push_back(nr);
        end
        if (starve == SMAX || mq.size() == 0) begin
            w = widx(im_addr);
            m_imv = 1; m_imd = refm[w]; m_ldd = 0; m_std = 0;
            starve = 0;
            chk("rnd fetch ram_we", ram_we, 0);
        end else begin
            r = mq.pop_front();
            w = widx(r.a);
            m_imv = 0;
            if (r.st) begin
                refm[w] = merge(refm[w], r.d, r.s);
                m_std = 1; m_ldd = 0;
                chk("rnd store ram_we", ram_we, 1);
                chk("rnd store ram_bwe", ram_bwe, r.s);
            end else begin
                m_ldata = refm[w];
                m_ldd = 1; m_std = 0;
                chk("rnd load ram_we", ram_we, 0);
            end
            if (starve < SMAX) starve++;
        end
        m_rdy = (mq.size() == 0);
    endtask

    vec_t tbl[11];
    int   rdy_low, ldd_cnt;

    initial begin
        tbl[0]  = mk(0, 0, 32'h0,    32'h0,        4'h0, 32'h40,   0, 32'h0,        0, 32'h0,        0);
        tbl[1]  = mk(1, 0, 32'h80,   32'h0,        4'h0, 32'h40,   1, 32'hDEADBEEF, 0, 32'h0,        0);
        tbl[2]  = mk(0, 0, 32'h0,    32'h0,        4'h0, 32'h40,   0, 32'h0,        1, 32'h12345678, 0);
        tbl[3]  = mk(0, 1, 32'h100,  32'hAABBCCDD, 4'h2, 32'h40,   1, 32'hDEADBEEF, 0, 32'h12345678, 0);
        tbl[4]  = mk(1, 0, 32'h100,  32'h0,        4'h0, 32'h40,   0, 32'h0,        0, 32'h12345678, 1);
        tbl[5]  = mk(0, 1, 32'h4040, 32'hCAFEF00D, 4'hF, 32'h40,   0, 32'h0,        1, 32'h1111CC11, 0);
        tbl[6]  = mk(1, 0, 32'h4040, 32'h0,        4'h0, 32'h40,   0, 32'h0,        0, 32'h1111CC11, 1);
        tbl[7]  = mk(0, 0, 32'h0,    32'h0,        4'h0, 32'h40,   0, 32'h0,        1, 32'hCAFEF00D, 0);
        tbl[8]  = mk(0, 0, 32'h0,    32'h0,        4'h0, 32'h4040, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
        tbl[9]  = mk(0, 0, 32'h0,    32'h0,        4'h0, 32'h4040, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
        tbl[10] = mk(0, 0, 32'h0,    32'h0,        4'h0, 32'h4040, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);

        bd(32'h10, 32'hDEADBEEF);
        bd(32'h20, 32'h12345678);
        bd(32'h40, 32'h11111111);
        step(0, 0, 0, 0, 0, 0, 32'h40);
        step(0, 0, 0, 0, 0, 0, 32'h40);
        chk("reset im_valid", im_valid, 0);
        chk("reset ld_done", ld_done, 0);
        chk("reset st_done", st_done, 0);
        chk("reset ready", ready, 1);
        chk("reset ram_we", ram_we, 0);
        chk("reset ram_bwe", ram_bwe, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset im_data", im_data, 0);
        chk("reset ld_data", ld_data, 0);

        for (int i = 0; i < 11; i++) begin
            step(1, tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].im);
            chk($sformatf("t%0d im_valid", i), im_valid, tbl[i].e_imv);
            if (tbl[i].e_imv) chk($sformatf("t%0d im_data", i), im_data, tbl[i].e_imd);
            chk($sformatf("t%0d ld_done", i), ld_done, tbl[i].e_ldd);
            chk($sformatf("t%0d ld_data", i), ld_data, tbl[i].e_ldata);
            chk($sformatf("t%0d st_done", i), st_done, tbl[i].e_std);
            chk($sformatf("t%0d ready", i), ready, 1);
        end
        chk("byte-merge mem[0x40]", mem[12'h040], 32'h1111CC11);
        chk("alias mem[0x10]", mem[12'h010], 32'hCAFEF00D);

        // Reset in the cycle after a load strobe swallows the completion.
        step(1, 1, 0, 32'h80, 0, 0, 32'h40);
        step(0, 0, 0, 0, 0, 0, 32'h40);
        chk("midrst ld_done", ld_done, 0);
        chk("midrst im_valid", im_valid, 0);
        step(1, 0, 0, 0, 0, 0, 32'h40);
        chk("postrst ld_done", ld_done, 0);
        chk("postrst ready", ready, 1);
        chk("postrst im_valid", im_valid, 0);
        step(1, 0, 0, 0, 0, 0, 32'h40);
        chk("resume im_valid", im_valid, 1);
        chk("resume im_data", im_data, 32'hCAFEF00D);

        // Saturating DM traffic: one forced fetch every SMAX+1 cycles.
        rdy_low = 0;
        ldd_cnt = 0;
        for (int c = 0; c <= 20; c++) begin
            step(1, 1, 0, 32'($urandom_range(0, 31)) << 2, 0, 0, 32'h40);
            if (c >= 1) begin
                chk($sformatf("stream c%0d im_valid", c), im_valid, ((c % 5) == 0));
                if (!ready) rdy_low++;
                if (ld_done) ldd_cnt++;
            end
        end
        chk("stream ready-low count", rdy_low, 4);
        chk("stream load count", ldd_cnt, 16);

        // Randomized traffic against the reference model.
        step(0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = $urandom;
            refm[i] = v;
            bd(i, v);
        end
        step(0, 0, 0, 0, 0, 0, 32'h0);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            int          k;
            logic [31:0] a, im;
            k  = $urandom_range(0, 9);
            a  = ($urandom & 32'hFFFFC000) | (32'($urandom_range(0, 31)) << 2)
                 | 32'($urandom_range(0, 3));
            im = ($urandom & 32'hFFFFC000) | (32'($urandom_range(0, 31)) << 2);
            step(1, (k <= 3) || (k == 7), (k >= 4 && k <= 7), a, $urandom,
                 4'($urandom_range(0, 15)), im);
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
